exe_hazard_ctrl: RTL and testbench

//  Sequencer for the execute-stage datapath: tracks in-flight destinations (EXE/MEM/WB).

---
 rtl/exe_ctrl_pkg.sv | 44 ++++
 rtl/exe_fwd_cmp.sv | 33 +++
 rtl/exe_hazard_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_exe_hazard_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_ctrl_pkg.sv
// Package: exe_ctrl_pkg
// Shared types for the execute-stage hazard controller.
//   fwd_sel_e    : forwarding source (register file, ALU_res_MEM, result_WB)
//   mc_state_e   : multi-cycle sequencer state
//   stage_tag_t  : per-stage destination tag {valid, wb_en, is_load, dest}
//   tag_writes() : "this stage will write the register a consumer reads"
package exe_ctrl_pkg;

    // Tag destination field is sized for the widest supported register
    // index; narrower indices are zero-extended on entry.
    localparam int unsigned TAG_DEST_W = 8;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_e;

    typedef struct packed {
        logic                  valid;
        logic                  wb_en;
        logic                  is_load;
        logic [TAG_DEST_W-1:0] dest;
    } stage_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '0;

    // A stage produces a source operand when it holds a valid, writing
    // instruction whose destination equals a source that is really read.
    // Register 0 never matches when it is hardwired.
    function automatic logic tag_writes(input stage_tag_t            t,
                                        input logic [TAG_DEST_W-1:0] src,
                                        input logic                  used,
                                        input logic                  zero_reg);
        return t.valid & t.wb_en & used & (t.dest == src) &
               ~(zero_reg & (src == '0));
    endfunction

endpackage

// File: rtl/exe_fwd_cmp.sv
// Module: exe_fwd_cmp
// Forwarding comparator for one source operand of the EXE instruction.
// MEM has priority over WB (youngest producer wins).
// Ports:
//   src      in  TAG_DEST_W  source register (zero-extended)
//   used     in  1           source is actually read
//   mem_tag  in  stage_tag_t MEM stage tag
//   wb_tag   in  stage_tag_t WB stage tag
//   sel      out fwd_sel_e   forwarding select
module exe_fwd_cmp
    import exe_ctrl_pkg::*;
#(
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [TAG_DEST_W-1:0] src,
    input  logic                  used,
    input  stage_tag_t            mem_tag,
    input  stage_tag_t            wb_tag,
    output fwd_sel_e              sel
);

    localparam logic ZR = (ZERO_REG != 0);

    always_comb begin
        sel = FWD_REG;
        if (tag_writes(mem_tag, src, used, ZR)) begin
            sel = FWD_MEM;
        end else if (tag_writes(wb_tag, src, used, ZR)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/exe_hazard_ctrl.sv
// Module: exe_hazard_ctrl
// Execute-stage sequencer: tracks EXE/MEM/WB destination tags, drives the
// operand/store forwarding selects, load-use and multi-cycle stalls, and
// EXE bubbles/holds.
// Configuration macro: EXE_FORWARDING_EN
//   defined   : MEM/WB forwarding plus a one-cycle load-use stall
//   undefined : selects tied to 0; stall while any in-flight writer
//               (EXE/MEM/WB) targets a used ID source
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   id_valid, id_src1/2/st, id_use1/2/st, id_dest, id_wb_en,
//   id_is_load, id_is_multi          decoded ID instruction
//   flush                            squash ID instruction and EXE slot
//   val1_sel, val2_sel, st_val_sel   forwarding selects for the EXE op
//   stall                            freeze PC and IF/ID
//   exe_bubble                       load a NOP into ID/EXE
//   exe_hold                         hold ID/EXE (multi-cycle op)
module exe_hazard_ctrl
    import exe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned MULTI_LAT  = 4,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic [REG_ADDR_W-1:0] id_src_st,
    input  logic                  id_use1,
    input  logic                  id_use2,
    input  logic                  id_use_st,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_is_load,
    input  logic                  id_is_multi,
    input  logic                  flush,
    output logic [SEL_W-1:0]      val1_sel,
    output logic [SEL_W-1:0]      val2_sel,
    output logic [SEL_W-1:0]      st_val_sel,
    output logic                  stall,
    output logic                  exe_bubble,
    output logic                  exe_hold
);

    localparam int unsigned      CNT_W   = $clog2(MULTI_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(MULTI_LAT - 1);
    localparam logic             ZR      = (ZERO_REG != 0);

    stage_tag_t            exe_q, mem_q, wb_q, id_tag;
    mc_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy, hazard, issue;
    logic [TAG_DEST_W-1:0] src1_x, src2_x, srcst_x;

    assign src1_x  = TAG_DEST_W'(id_src1);
    assign src2_x  = TAG_DEST_W'(id_src2);
    assign srcst_x = TAG_DEST_W'(id_src_st);
    assign id_tag  = '{valid: 1'b1, wb_en: id_wb_en, is_load: id_is_load,
                       dest: TAG_DEST_W'(id_dest)};

    always_comb begin
        logic rd_exe, rd_mem, rd_wb;
        rd_exe = tag_writes(exe_q, src1_x, id_use1, ZR) |
                 tag_writes(exe_q, src2_x, id_use2, ZR) |
                 tag_writes(exe_q, srcst_x, id_use_st, ZR);
        rd_mem = tag_writes(mem_q, src1_x, id_use1, ZR) |
                 tag_writes(mem_q, src2_x, id_use2, ZR) |
                 tag_writes(mem_q, srcst_x, id_use_st, ZR);
        rd_wb  = tag_writes(wb_q, src1_x, id_use1, ZR) |
                 tag_writes(wb_q, src2_x, id_use2, ZR) |
                 tag_writes(wb_q, srcst_x, id_use_st, ZR);
`ifdef EXE_FORWARDING_EN
        hazard = id_valid & exe_q.is_load & rd_exe;
`else
        hazard = id_valid & (rd_exe | rd_mem | rd_wb);
`endif
    end

    assign issue = id_valid & ~stall & ~flush;

    // Multi-cycle sequencer: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: entry is decided while the op is still in ID, so the
    // final un-held EXE cycle of a multi op never re-arms the sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == BUSY) begin
            if (cnt_q == CNT_END) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (issue && id_is_multi) begin
            state_d = BUSY;
            cnt_d   = CNT_ONE;
        end
    end

    // Outputs: flush dominates; BUSY governs over a pending load-use.
    always_comb begin
        busy       = (state_q == BUSY);
        exe_hold   = busy & ~flush;
        stall      = ~flush & (busy | hazard);
        exe_bubble = flush | (~busy & hazard);
    end

    // MEM takes a bubble on every BUSY cycle, including one that is
    // flushed: the squashed multi op must never reach writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_q <= TAG_BUBBLE;
            mem_q <= TAG_BUBBLE;
            wb_q  <= TAG_BUBBLE;
        end else begin
            wb_q  <= mem_q;
            mem_q <= busy ? TAG_BUBBLE : exe_q;
            if (!exe_hold) begin
                exe_q <= issue ? id_tag : TAG_BUBBLE;
            end
        end
    end

`ifdef EXE_FORWARDING_EN
    logic [TAG_DEST_W-1:0] exe_src1, exe_src2, exe_srcst;
    logic                  exe_use1, exe_use2, exe_usest;
    fwd_sel_e              live1, live2, livest;
    fwd_sel_e              held1, held2, heldst;
    fwd_sel_e              out1, out2, outst;
    logic                  sel_frozen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_src1  <= '0;
            exe_src2  <= '0;
            exe_srcst <= '0;
            exe_use1  <= 1'b0;
            exe_use2  <= 1'b0;
            exe_usest <= 1'b0;
        end else if (!exe_hold) begin
            exe_src1  <= src1_x;
            exe_src2  <= src2_x;
            exe_srcst <= srcst_x;
            exe_use1  <= issue & id_use1;
            exe_use2  <= issue & id_use2;
            exe_usest <= issue & id_use_st;
        end
    end

    exe_fwd_cmp #(.ZERO_REG(ZERO_REG)) u_fwd_src1 (
        .src(exe_src1), .used(exe_use1), .mem_tag(mem_q), .wb_tag(wb_q), .sel(live1)
    );
    exe_fwd_cmp #(.ZERO_REG(ZERO_REG)) u_fwd_src2 (
        .src(exe_src2), .used(exe_use2), .mem_tag(mem_q), .wb_tag(wb_q), .sel(live2)
    );
    exe_fwd_cmp #(.ZERO_REG(ZERO_REG)) u_fwd_src_st (
        .src(exe_srcst), .used(exe_usest), .mem_tag(mem_q), .wb_tag(wb_q), .sel(livest)
    );

    // First BUSY cycle shows the live selects; later BUSY cycles replay
    // them because the producers drain out of MEM/WB during the hold.
    assign sel_frozen = busy && (cnt_q != CNT_ONE);
    assign out1  = sel_frozen ? held1  : live1;
    assign out2  = sel_frozen ? held2  : live2;
    assign outst = sel_frozen ? heldst : livest;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held1  <= FWD_REG;
            held2  <= FWD_REG;
            heldst <= FWD_REG;
        end else begin
            held1  <= out1;
            held2  <= out2;
            heldst <= outst;
        end
    end

    assign val1_sel   = SEL_W'(out1);
    assign val2_sel   = SEL_W'(out2);
    assign st_val_sel = SEL_W'(outst);
`else
    assign val1_sel   = '0;
    assign val2_sel   = '0;
    assign st_val_sel = '0;
`endif

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
module tb_exe_hazard_ctrl;

    localparam int REG_ADDR_W = 5;
    localparam int SEL_W      = 2;
    localparam int MULTI_LAT  = 4;
    localparam int ZERO_REG   = 1;
`ifdef EXE_FORWARDING_EN
    localparam bit FW = 1'b1;
`else
    localparam bit FW = 1'b0;
`endif

    logic                  clk, rst_n;
    logic                  id_valid, id_use1, id_use2, id_use_st;
    logic [REG_ADDR_W-1:0] id_src1, id_src2, id_src_st, id_dest;
    logic                  id_wb_en, id_is_load, id_is_multi, flush;
    logic [SEL_W-1:0]      val1_sel, val2_sel, st_val_sel;
    logic                  stall, exe_bubble, exe_hold;

    exe_hazard_ctrl #(
        .REG_ADDR_W(REG_ADDR_W),
        .SEL_W     (SEL_W),
        .MULTI_LAT (MULTI_LAT),
        .ZERO_REG  (ZERO_REG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_src_st(id_src_st),
        .id_use1(id_use1), .id_use2(id_use2), .id_use_st(id_use_st),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_is_load(id_is_load),
        .id_is_multi(id_is_multi), .flush(flush),
        .val1_sel(val1_sel), .val2_sel(val2_sel), .st_val_sel(st_val_sel),
        .stall(stall), .exe_bubble(exe_bubble), .exe_hold(exe_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit v; bit wb; bit ld;
        int dest; int s1; int s2; int sst;
        bit u1; bit u2; bit ust;
    } instr_t;

    typedef struct {
        int s1; int s2; int sst;
        bit stall; bit bubble; bit hold;
    } exp_t;

    instr_t pe, pm, pw;          // instructions in EXE, MEM, WB
    int     hold_left;           // remaining held cycles of the EXE multi op
    int     busy_age;            // held cycles already elapsed
    int     cap1, cap2, capst;   // selects seen on the first held cycle
    int     n_checks = 0;
    int     n_fail   = 0;

    function automatic instr_t nop_i();
        instr_t t;
        t = '{default: 0};
        return t;
    endfunction

    function automatic bit writes(instr_t t, int r, bit u);
        return t.v && t.wb && u && (t.dest == r) && !(ZERO_REG != 0 && r == 0);
    endfunction

    function automatic int pick(instr_t m, instr_t w, int r, bit u);
        if (writes(m, r, u)) return 1;
        if (writes(w, r, u)) return 2;
        return 0;
    endfunction

    function automatic bit id_reads(instr_t t);
        return writes(t, int'(id_src1), id_use1) ||
               writes(t, int'(id_src2), id_use2) ||
               writes(t, int'(id_src_st), id_use_st);
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        bit   busy, haz;
        busy = hold_left > 0;
        if (busy && busy_age > 0) begin
            e.s1 = cap1; e.s2 = cap2; e.sst = capst;
        end else begin
            e.s1  = pick(pm, pw, pe.s1, pe.u1);
            e.s2  = pick(pm, pw, pe.s2, pe.u2);
            e.sst = pick(pm, pw, pe.sst, pe.ust);
        end
        if (FW) begin
            haz = id_valid && pe.ld && id_reads(pe);
        end else begin
            haz = id_valid && (id_reads(pe) || id_reads(pm) || id_reads(pw));
            e.s1 = 0; e.s2 = 0; e.sst = 0;
        end
        e.stall  = !flush && (busy || haz);
        e.bubble = flush || (!busy && haz);
        e.hold   = busy && !flush;
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t   e;
        bit     busy, issue;
        instr_t idi;
        if (!rst_n) begin
            pe = nop_i(); pm = nop_i(); pw = nop_i();
            hold_left = 0; busy_age = 0;
            cap1 = 0; cap2 = 0; capst = 0;
        end else begin
            e     = expect_now();
            busy  = hold_left > 0;
            issue = id_valid && !e.stall && !flush;
            if (busy && busy_age == 0) begin
                cap1 = e.s1; cap2 = e.s2; capst = e.sst;
            end
            idi = '{v: 1'b1, wb: id_wb_en, ld: id_is_load, dest: int'(id_dest),
                    s1: int'(id_src1), s2: int'(id_src2), sst: int'(id_src_st),
                    u1: id_use1, u2: id_use2, ust: id_use_st};
            pw = pm;
            pm = busy ? nop_i() : pe;
            if (!e.hold) pe = issue ? idi : nop_i();
            if (flush)                        hold_left = 0;
            else if (busy)                    hold_left = hold_left - 1;
            else if (issue && id_is_multi)    hold_left = MULTI_LAT - 1;
            busy_age = (busy && hold_left > 0) ? busy_age + 1 : 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // compare process: every cycle, mid-period
    always @(negedge clk) begin
        exp_t e;
        e = expect_now();
        chk("val1_sel",   int'(val1_sel),   e.s1);
        chk("val2_sel",   int'(val2_sel),   e.s2);
        chk("st_val_sel", int'(st_val_sel), e.sst);
        chk("stall",      int'(stall),      int'(e.stall));
        chk("exe_bubble", int'(exe_bubble), int'(e.bubble));
        chk("exe_hold",   int'(exe_hold),   int'(e.hold));
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        id_valid = 0; id_src1 = '0; id_src2 = '0; id_src_st = '0;
        id_use1 = 0; id_use2 = 0; id_use_st = 0; id_dest = '0;
        id_wb_en = 0; id_is_load = 0; id_is_multi = 0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one instruction in ID until it issues; called and returns
    // 1 time unit after a rising edge.
    task automatic send(input int s1, input int s2, input int sst,
                        input bit u1, input bit u2, input bit ust,
                        input int d, input bit wb, input bit ld, input bit mul,
                        output int stalls);
        bit done;
        done = 0;
        stalls = 0;
        id_valid = 1;
        id_src1 = REG_ADDR_W'(s1); id_src2 = REG_ADDR_W'(s2); id_src_st = REG_ADDR_W'(sst);
        id_use1 = u1; id_use2 = u2; id_use_st = ust;
        id_dest = REG_ADDR_W'(d); id_wb_en = wb; id_is_load = ld; id_is_multi = mul;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (!stall) done = 1;
            else begin
                stalls++;
                @(posedge clk); #1;
            end
        end
        chk("issue_within_bound", int'(done), 1);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        int st;
        rst_n = 0; flush = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_val1", int'(val1_sel), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_bubble", int'(exe_bubble), 0);
        chk("rst_hold", int'(exe_hold), 0);
        @(posedge clk); #1;
        rst_n = 1;
        drain(2);

        // ADD r3,r1,r2 ; SUB r4,r3,r1
        send(1, 2, 0, 1, 1, 0, 3, 1, 0, 0, st);
        send(3, 1, 0, 1, 1, 0, 4, 1, 0, 0, st);
        chk("sub_stall_cycles", st, FW ? 0 : 3);
        @(negedge clk);
        chk("sub_val1", int'(val1_sel), FW ? 1 : 0);
        chk("sub_val2", int'(val2_sel), 0);
        drain(4);

        // ADD r3 ; NOP ; ORR r5,r1,r3
        send(1, 2, 0, 1, 1, 0, 3, 1, 0, 0, st);
        drain(1);
        send(1, 3, 0, 1, 1, 0, 5, 1, 0, 0, st);
        chk("orr_stall_cycles", st, FW ? 0 : 2);
        @(negedge clk);
        chk("orr_val2_wb", int'(val2_sel), FW ? 2 : 0);
        chk("orr_val1", int'(val1_sel), 0);
        drain(4);

        // ADD r3 ; ADD r3 ; ORR r5,r1,r3  (MEM wins over WB)
        send(1, 2, 0, 1, 1, 0, 3, 1, 0, 0, st);
        send(1, 2, 0, 1, 1, 0, 3, 1, 0, 0, st);
        send(1, 3, 0, 1, 1, 0, 5, 1, 0, 0, st);
        chk("orr2_stall_cycles", st, FW ? 0 : 3);
        @(negedge clk);
        chk("orr2_val2_mem", int'(val2_sel), FW ? 1 : 0);
        drain(4);

        // LDR r2,[r1] ; ADD r6,r2,r2
        send(1, 0, 0, 1, 0, 0, 2, 1, 1, 0, st);
        send(2, 2, 0, 1, 1, 0, 6, 1, 0, 0, st);
        chk("ldu_stall_cycles", st, FW ? 1 : 3);
        @(negedge clk);
        chk("ldu_val1", int'(val1_sel), FW ? 2 : 0);
        chk("ldu_val2", int'(val2_sel), FW ? 2 : 0);
        drain(4);

        // ADD r0 ; SUB r4,r0,r0  (hardwired zero)
        send(1, 2, 0, 1, 1, 0, 0, 1, 0, 0, st);
        send(0, 0, 0, 1, 1, 0, 4, 1, 0, 0, st);
        chk("r0_stall_cycles", st, 0);
        @(negedge clk);
        chk("r0_val1", int'(val1_sel), 0);
        chk("r0_val2", int'(val2_sel), 0);
        drain(4);

        // ADD r3 ; STR r3,[r1]
        send(1, 2, 0, 1, 1, 0, 3, 1, 0, 0, st);
        send(1, 0, 3, 1, 0, 1, 0, 0, 0, 0, st);
        chk("str_stall_cycles", st, FW ? 0 : 3);
        @(negedge clk);
        chk("str_st_sel", int'(st_val_sel), FW ? 1 : 0);
        drain(4);

        // MUL r7,r1,r2: held three cycles then released
        send(1, 2, 0, 1, 1, 0, 7, 1, 0, 1, st);
        chk("mul_issue_stalls", st, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mul_hold", int'(exe_hold), (i < 3) ? 1 : 0);
            chk("mul_stall", int'(stall), (i < 3) ? 1 : 0);
            @(posedge clk); #1;
        end
        drain(4);

        // MUL with flush in its second cycle
        send(1, 2, 0, 1, 1, 0, 7, 1, 0, 1, st);
        @(negedge clk);
        chk("mulf_hold_c1", int'(exe_hold), 1);
        @(posedge clk); #1;
        flush = 1;
        @(negedge clk);
        chk("flush_bubble", int'(exe_bubble), 1);
        chk("flush_stall", int'(stall), 0);
        chk("flush_hold", int'(exe_hold), 0);
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk);
        chk("post_flush_hold", int'(exe_hold), 0);
        chk("post_flush_stall", int'(stall), 0);
        drain(4);

        // async reset mid-BUSY
        send(1, 2, 0, 1, 1, 0, 7, 1, 0, 1, st);
        @(negedge clk);
        chk("mulr_hold_c1", int'(exe_hold), 1);
        #2;
        rst_n = 0;
        #1;
        chk("arst_stall", int'(stall), 0);
        chk("arst_hold", int'(exe_hold), 0);
        chk("arst_bubble", int'(exe_bubble), 0);
        chk("arst_sel", int'(val1_sel) + int'(val2_sel) + int'(st_val_sel), 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_hold", int'(exe_hold), 0);
        chk("post_rst_stall", int'(stall), 0);
        @(posedge clk); #1;

        // randomized traffic over a small register set
        for (int c = 0; c < 3000; c++) begin
            id_valid    = ($urandom_range(0, 3) != 0);
            id_src1     = REG_ADDR_W'($urandom_range(0, 3));
            id_src2     = REG_ADDR_W'($urandom_range(0, 3));
            id_src_st   = REG_ADDR_W'($urandom_range(0, 3));
            id_use1     = $urandom_range(0, 1) != 0;
            id_use2     = $urandom_range(0, 1) != 0;
            id_use_st   = $urandom_range(0, 3) == 0;
            id_dest     = REG_ADDR_W'($urandom_range(0, 3));
            id_wb_en    = $urandom_range(0, 4) != 0;
            id_is_load  = $urandom_range(0, 3) == 0;
            id_is_multi = $urandom_range(0, 7) == 0;
            flush       = $urandom_range(0, 15) == 0;
            @(posedge clk); #1;
        end
        idle_inputs();
        flush = 0;
        drain(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
